// File: rtl/trig_counter_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : trig_counter_bank_if
// Description : Host-side trigger/wire bundle for the trigger counter bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface trig_counter_bank_if #(
    parameter int NCH    = 4,
    parameter int WIDTH  = 32,
    parameter int STEP_W = 8
);
    logic [NCH-1:0]       trig_clr;
    logic [NCH-1:0]       trig_load;
    logic [NCH-1:0]       trig_up;
    logic [NCH-1:0]       trig_down;
    logic [WIDTH-1:0]     load_value;
    logic [STEP_W-1:0]    step;
    logic [NCH-1:0]       mode_sat;
    logic                 snap_req;
    logic                 ovf_clr;
    logic [NCH*WIDTH-1:0] count;
    logic [NCH*WIDTH-1:0] snap_data;
    logic                 snap_valid;
    logic [NCH-1:0]       ovf;

    modport master (
        output trig_clr, trig_load, trig_up, trig_down,
        output load_value, step, mode_sat, snap_req, ovf_clr,
        input  count, snap_data, snap_valid, ovf
    );

    modport slave (
        input  trig_clr, trig_load, trig_up, trig_down,
        input  load_value, step, mode_sat, snap_req, ovf_clr,
        output count, snap_data, snap_valid, ovf
    );
endinterface
`default_nettype wire

// File: rtl/trig_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : trig_counter_bank
// Description : NCH trigger-driven up/down counters with wrap/saturate modes,
//               sticky overflow flags and a bank-wide coherent snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
module trig_counter_bank #(
    parameter int NCH    = 4,
    parameter int WIDTH  = 32,
    parameter int STEP_W = 8
) (
    input  wire logic          sys_clk,
    input  wire logic          reset,
    trig_counter_bank_if.slave bus
);

    // Arithmetic width wide enough for both operands plus a carry bit
    localparam int AW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;
    localparam logic [WIDTH-1:0] C_MAX = '1;

    logic [AW-1:0] w_step_a;
    logic          r_snap_valid;

    assign w_step_a = {{(AW-STEP_W){1'b0}}, bus.step};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_snap;
        logic             r_ovf;
        logic [WIDTH-1:0] w_next_cnt;
        logic [WIDTH-1:0] w_diff;
        logic [AW-1:0]    w_cnt_a;
        logic [AW-1:0]    w_sum;
        logic             w_carry;
        logic             w_borrow;
        logic             w_evt;

        assign w_cnt_a  = {{(AW-WIDTH){1'b0}}, r_cnt};
        assign w_sum    = w_cnt_a + w_step_a;
        assign w_carry  = |w_sum[AW-1:WIDTH];
        assign w_borrow = (w_step_a > w_cnt_a);
        // Low bits of the difference are exact modulo 2^WIDTH
        assign w_diff   = r_cnt - w_step_a[WIDTH-1:0];

        always_comb begin
            w_next_cnt = r_cnt;
            w_evt      = 1'b0;
            if (bus.trig_clr[i]) begin
                w_next_cnt = '0;
            end else if (bus.trig_load[i]) begin
                w_next_cnt = bus.load_value;
            end else if (bus.trig_up[i] && !bus.trig_down[i]) begin
                w_evt      = w_carry;
                w_next_cnt = (w_carry && bus.mode_sat[i]) ? C_MAX : w_sum[WIDTH-1:0];
            end else if (bus.trig_down[i] && !bus.trig_up[i]) begin
                w_evt      = w_borrow;
                w_next_cnt = (w_borrow && bus.mode_sat[i]) ? '0 : w_diff;
            end
        end

        always_ff @(posedge sys_clk) begin
            if (reset) begin
                r_cnt  <= '0;
                r_snap <= '0;
                r_ovf  <= 1'b0;
            end else begin
                r_cnt <= w_next_cnt;
                // A new event in the clearing cycle keeps the flag set
                r_ovf <= w_evt | (r_ovf & ~bus.ovf_clr);
                if (bus.snap_req) begin
                    r_snap <= r_cnt;
                end
            end
        end

        assign bus.count[i*WIDTH +: WIDTH]     = r_cnt;
        assign bus.snap_data[i*WIDTH +: WIDTH] = r_snap;
        assign bus.ovf[i]                      = r_ovf;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= bus.snap_req;
        end
    end

    assign bus.snap_valid = r_snap_valid;

endmodule
`default_nettype wire
